// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM duty calculator and generator.
package pwm_pkg;

  localparam int RESOLUTION = 16;
  localparam int MIN_PERIOD = 2;

  localparam logic [RESOLUTION-1:0] MIN_PERIOD_W = RESOLUTION'(MIN_PERIOD);
  localparam logic [RESOLUTION-1:0] ONE_W        = RESOLUTION'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MUL       = 2'd1,
    ST_CLAMP     = 2'd2,
    ST_WAIT_SYNC = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_duty_calc_seq_mul.sv
// Unsigned shift-add multiplier, one partial product per clock, W x W -> 2W.
module seq_mul
  import pwm_pkg::*;
#(
  parameter int W = RESOLUTION
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] product_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] a_q, a_d, acc_q, acc_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      a_d    = {{W{1'b0}}, a_i};
      b_d    = b_i;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done marks the final accumulation step; product_o is complete the cycle after.
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_q;

endmodule

// File: rtl/pwm_duty_calc.sv
// Converts a (period, duty) request into clamped on/off tick counts and applies them atomically.
// Handshake: a request transfers in any cycle where req_valid && req_ready; req_ready is high only in IDLE.
module pwm_duty_calc
  import pwm_pkg::*;
(
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [RESOLUTION-1:0] req_period,
  input  logic [RESOLUTION-1:0] req_duty,
  input  logic                  sync_en,
  input  logic                  pwm_in,
  output logic [RESOLUTION-1:0] onperiod,
  output logic [RESOLUTION-1:0] offperiod,
  output logic                  force_low,
  output logic                  upd_done,
  output logic                  err
);

  state_e                  state_q, state_d;
  logic [RESOLUTION-1:0]   period_q, period_d;
  logic [RESOLUTION-1:0]   pend_on_q, pend_on_d, pend_off_q, pend_off_d;
  logic [RESOLUTION-1:0]   on_q, on_d, off_q, off_d;
  logic                    force_low_q, force_low_d;
  logic                    upd_done_q, upd_done_d;
  logic                    err_q, err_d;
  logic                    pwm_q;
  logic                    rise;

  logic                    mul_start, mul_busy, mul_done;
  logic [2*RESOLUTION-1:0] mul_product;
  logic [RESOLUTION-1:0]   high, new_on, new_off;

  seq_mul #(.W(RESOLUTION)) u_mul (
    .clk_i     (clkin),
    .rst_ni    (rst_n),
    .start_i   (mul_start),
    .a_i       (req_period),
    .b_i       (req_duty),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign rise = pwm_in & ~pwm_q;

  // Clamping high to [1, period-1] keeps both subtractions from wrapping.
  always_comb begin
    high = mul_product[2*RESOLUTION-1:RESOLUTION];
    if (high < ONE_W) high = ONE_W;
    if (high > period_q - ONE_W) high = period_q - ONE_W;
    new_on  = high - ONE_W;
    new_off = period_q - high - ONE_W;
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    pend_on_d   = pend_on_q;
    pend_off_d  = pend_off_q;
    on_d        = on_q;
    off_d       = off_q;
    force_low_d = force_low_q;
    upd_done_d  = 1'b0;
    err_d       = 1'b0;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !mul_busy) begin
          if (req_period < MIN_PERIOD_W) begin
            err_d = 1'b1;
          end else if (req_duty == '0) begin
            force_low_d = 1'b1;
            upd_done_d  = 1'b1;
          end else begin
            mul_start = 1'b1;
            period_d  = req_period;
            state_d   = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_CLAMP;
      end
      ST_CLAMP: begin
        if (!sync_en) begin
          on_d        = new_on;
          off_d       = new_off;
          force_low_d = 1'b0;
          upd_done_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          pend_on_d  = new_on;
          pend_off_d = new_off;
          state_d    = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (rise || !sync_en) begin
          on_d        = pend_on_q;
          off_d       = pend_off_q;
          force_low_d = 1'b0;
          upd_done_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      period_q    <= '0;
      pend_on_q   <= '0;
      pend_off_q  <= '0;
      on_q        <= '0;
      off_q       <= '0;
      force_low_q <= 1'b1;
      upd_done_q  <= 1'b0;
      err_q       <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      pend_on_q   <= pend_on_d;
      pend_off_q  <= pend_off_d;
      on_q        <= on_d;
      off_q       <= off_d;
      force_low_q <= force_low_d;
      upd_done_q  <= upd_done_d;
      err_q       <= err_d;
      pwm_q       <= pwm_in;
    end
  end

  assign req_ready = (state_q == ST_IDLE) && !mul_busy;
  assign onperiod  = on_q;
  assign offperiod = off_q;
  assign force_low = force_low_q;
  assign upd_done  = upd_done_q;
  assign err       = err_q;

endmodule
